// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: load/store funct3 encodings
// and the default data-memory depth.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEPTH_WORDS_DEF = 64;

endpackage : riscv_pkg

// File: rtl/data_mem_cc.sv
// Word-organised data RAM with per-byte write enables. Writes land on the
// rising edge; reads are asynchronous so the M stage sees data in-cycle.
// Contents are deliberately not reset.
module data_mem_cc
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule : data_mem_cc

// File: rtl/memory_stage_cc.sv
// M stage of the RV32I pipeline plus the M/W register bank. Performs byte,
// half and word loads/stores on the local data RAM, suppresses misaligned
// accesses and reports them both per-instruction and as a sticky flag.
module memory_stage_cc
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic        StallM,
  input  logic        FlushW,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic        MisalignW,
  output logic        MisalignErr
);

  logic [1:0]        byte_off;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rdata_word;

  logic        is_half;
  logic        is_word;
  logic        st_valid;
  logic        mis_m;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] read_data_m;

  logic        reg_write_q,  reg_write_d;
  logic        result_src_q, result_src_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] read_data_q,  read_data_d;
  logic [4:0]  rd_q,         rd_d;
  logic        misalign_q,   misalign_d;
  logic        mis_err_q,    mis_err_d;

  // Upper address bits are ignored, so accesses wrap around the RAM.
  assign byte_off = ALUResultM[1:0];
  assign word_idx = ALUResultM[ADDR_W+1:2];

  // Access decode: alignment check, store byte enables, lane-replicated data.
  always_comb begin
    is_half   = (funct3M == F3_H) || (funct3M == F3_HU);
    is_word   = (funct3M == F3_W);
    st_valid  = MemWriteM && ((funct3M == F3_B) || (funct3M == F3_H) || (funct3M == F3_W));
    mis_m     = (ResultSrcM || st_valid) &&
                ((is_half && byte_off[0]) || (is_word && (byte_off != 2'b00)));
    mem_we    = st_valid && !mis_m && !StallM && rst_n;
    mem_be    = 4'b0000;
    mem_wdata = WriteDataM;
    case (funct3M)
      F3_B: begin
        mem_be    = 4'b0001 << byte_off;
        mem_wdata = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        mem_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{WriteDataM[15:0]}};
      end
      F3_W: begin
        mem_be    = 4'b1111;
        mem_wdata = WriteDataM;
      end
      default: begin
        mem_be    = 4'b0000;
        mem_wdata = WriteDataM;
      end
    endcase
  end

  data_mem_cc #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk    (clk),
    .we_i   (mem_we),
    .be_i   (mem_be),
    .addr_i (word_idx),
    .wdata_i(mem_wdata),
    .rdata_o(rdata_word)
  );

  // Lane select and sign/zero extension; unknown funct3 passes the word through.
  always_comb begin
    case (byte_off)
      2'd0:    lane_b = rdata_word[7:0];
      2'd1:    lane_b = rdata_word[15:8];
      2'd2:    lane_b = rdata_word[23:16];
      default: lane_b = rdata_word[31:24];
    endcase
    lane_h = byte_off[1] ? rdata_word[31:16] : rdata_word[15:0];
    case (funct3M)
      F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_ext = {24'h0, lane_b};
      F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_ext = {16'h0, lane_h};
      default: load_ext = rdata_word;
    endcase
    read_data_m = mis_m ? 32'h0 : load_ext;
  end

  // Next state of the W bank: stall holds, flush inserts a bubble.
  always_comb begin
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    rd_d         = rd_q;
    misalign_d   = misalign_q;
    mis_err_d    = mis_err_q | (mis_m & ~StallM);
    if (!StallM) begin
      if (FlushW) begin
        reg_write_d  = 1'b0;
        result_src_d = 1'b0;
        alu_result_d = 32'h0;
        read_data_d  = 32'h0;
        rd_d         = 5'd0;
        misalign_d   = 1'b0;
      end else begin
        reg_write_d  = RegWriteM & ~mis_m;
        result_src_d = ResultSrcM;
        alu_result_d = ALUResultM;
        read_data_d  = read_data_m;
        rd_d         = RdM;
        misalign_d   = mis_m;
      end
    end
  end

  // W register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      alu_result_q <= 32'h0;
      read_data_q  <= 32'h0;
      rd_q         <= 5'd0;
      misalign_q   <= 1'b0;
      mis_err_q    <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
      misalign_q   <= misalign_d;
      mis_err_q    <= mis_err_d;
    end
  end

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign ALUResultW  = alu_result_q;
  assign ReadDataW   = read_data_q;
  assign RdW         = rd_q;
  assign MisalignW   = misalign_q;
  assign MisalignErr = mis_err_q;

endmodule : memory_stage_cc

// File: tb/tb_memory_stage_cc.sv
// Bench for memory_stage_cc: byte-addressed reference model checked every
// cycle, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_memory_stage_cc;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, ResultSrcM, MemWriteM, StallM, FlushW;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        RegWriteW, ResultSrcW, MisalignW, MisalignErr;
  logic [31:0] ALUResultW, ReadDataW;
  logic [4:0]  RdW;

  int checks = 0;
  int failures = 0;

  memory_stage_cc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .StallM     (StallM),
    .FlushW     (FlushW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .MisalignW  (MisalignW),
    .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  // Reference model: 256-byte memory (64 words, byte addresses wrap at 8 bits).
  logic [7:0]  mdl_mem [256];
  logic        e_rw, e_rs, e_mis, e_err;
  logic [31:0] e_alu, e_rd_data;
  logic [4:0]  e_rd;

  function automatic logic [31:0] mdl_read(input logic [2:0] f3, input logic [7:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = mdl_mem[a];
    h = {mdl_mem[{a[7:1], 1'b1}], mdl_mem[{a[7:1], 1'b0}]};
    w = {mdl_mem[{a[7:2], 2'd3}], mdl_mem[{a[7:2], 2'd2}],
         mdl_mem[{a[7:2], 2'd1}], mdl_mem[{a[7:2], 2'd0}]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  logic [7:0] m_a;
  logic       m_store, m_size_h, m_size_w, m_mis;

  always @(posedge clk) begin
    m_a      = ALUResultM[7:0];
    m_size_h = (funct3M == 3'd1) || (funct3M == 3'd5);
    m_size_w = (funct3M == 3'd2);
    m_store  = MemWriteM && (funct3M <= 3'd2);
    m_mis    = (ResultSrcM || m_store) &&
               ((m_size_h && m_a[0]) || (m_size_w && (m_a % 4 != 0)));
    if (!rst_n) begin
      {e_rw, e_rs, e_mis, e_err} = 4'b0;
      e_alu = 0; e_rd_data = 0; e_rd = 0;
    end else if (!StallM) begin
      if (m_mis) e_err = 1'b1;
      if (FlushW) begin
        {e_rw, e_rs, e_mis} = 3'b0;
        e_alu = 0; e_rd_data = 0; e_rd = 0;
      end else begin
        e_rw      = RegWriteM && !m_mis;
        e_rs      = ResultSrcM;
        e_alu     = ALUResultM;
        e_rd_data = m_mis ? 32'h0 : mdl_read(funct3M, m_a);
        e_rd      = RdM;
        e_mis     = m_mis;
      end
      if (m_store && !m_mis) begin
        case (funct3M)
          3'd0: mdl_mem[m_a] = WriteDataM[7:0];
          3'd1: begin
            mdl_mem[m_a]     = WriteDataM[7:0];
            mdl_mem[m_a + 1] = WriteDataM[15:8];
          end
          default: for (int k = 0; k < 4; k++) mdl_mem[m_a + 8'(k)] = WriteDataM[8*k +: 8];
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, shortly after each edge.
  always @(posedge clk) begin
    #1;
    chk("RegWriteW",   32'(RegWriteW),   32'(e_rw));
    chk("ResultSrcW",  32'(ResultSrcW),  32'(e_rs));
    chk("ALUResultW",  ALUResultW,       e_alu);
    chk("ReadDataW",   ReadDataW,        e_rd_data);
    chk("RdW",         32'(RdW),         32'(e_rd));
    chk("MisalignW",   32'(MisalignW),   32'(e_mis));
    chk("MisalignErr", 32'(MisalignErr), 32'(e_err));
  end

  task automatic step(input logic rst, input logic rw, input logic rs, input logic mw,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd, input logic st, input logic fl);
    rst_n = rst; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = a; WriteDataM = wd; RdM = rd; StallM = st; FlushW = fl;
    @(negedge clk);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    step(1, 0, 0, 1, f3, a, wd, 0, 0, 0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    step(1, 1, 1, 0, f3, a, 32'h0, rd, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    chk("reset_RegWriteW", 32'(RegWriteW), 32'h0);
    chk("reset_ReadDataW", ReadDataW, 32'h0);
    chk("reset_MisalignErr", 32'(MisalignErr), 32'h0);

    for (int i = 0; i < 64; i++) store(F3_W, 32'(i * 4), 32'h0);

    store(F3_W, 32'h10, 32'hDEADBEEF);
    load(F3_W, 32'h10, 5'd5);
    chk("t1_lw", ReadDataW, 32'hDEADBEEF);
    chk("t1_regwrite", 32'(RegWriteW), 32'h1);
    chk("t1_rd", 32'(RdW), 32'd5);

    store(F3_W, 32'h10, 32'h0);
    store(F3_B, 32'h13, 32'h80);
    load(F3_B, 32'h13, 5'd6);
    chk("t2_lb", ReadDataW, 32'hFFFFFF80);
    load(F3_BU, 32'h13, 5'd6);
    chk("t2_lbu", ReadDataW, 32'h00000080);
    load(F3_W, 32'h10, 5'd6);
    chk("t2_lw", ReadDataW, 32'h80000000);
    store(F3_B, 32'h50, 32'h7F);
    load(F3_B, 32'h50, 5'd6);
    chk("t2_lb_pos", ReadDataW, 32'h0000007F);

    store(F3_H, 32'h22, 32'h0000DADA);
    load(F3_H, 32'h22, 5'd3);
    chk("t3_lh", ReadDataW, 32'hFFFFDADA);
    load(F3_HU, 32'h22, 5'd3);
    chk("t3_lhu", ReadDataW, 32'h0000DADA);
    load(F3_H, 32'h21, 5'd3);
    chk("t3_mis_w", 32'(MisalignW), 32'h1);
    chk("t3_mis_rw", 32'(RegWriteW), 32'h0);
    chk("t3_mis_data", ReadDataW, 32'h0);
    chk("t3_mis_err", 32'(MisalignErr), 32'h1);
    load(F3_W, 32'h20, 5'd3);
    chk("t3_lw", ReadDataW, 32'hDADA0000);
    chk("t3_err_sticky", 32'(MisalignErr), 32'h1);
    chk("t3_mis_clear", 32'(MisalignW), 32'h0);
    store(F3_W, 32'h31, 32'h11111111);
    load(F3_W, 32'h30, 5'd3);
    chk("t3_sw_suppressed", ReadDataW, 32'h0);

    store(F3_W, 32'h100, 32'h12345678);
    load(F3_W, 32'h000, 5'd7);
    chk("t4_wrap", ReadDataW, 32'h12345678);

    step(1, 0, 0, 1, F3_W, 32'h40, 32'hCAFEF00D, 5'd0, 1, 0);
    chk("t5_stall_rd", 32'(RdW), 32'd7);
    chk("t5_stall_data", ReadDataW, 32'h12345678);
    chk("t5_stall_rw", 32'(RegWriteW), 32'h1);
    load(F3_W, 32'h40, 5'd8);
    chk("t5_no_write", ReadDataW, 32'h0);
    step(1, 1, 1, 0, F3_W, 32'h40, 32'h0, 5'd9, 0, 1);
    chk("t5_flush_rw", 32'(RegWriteW), 32'h0);
    chk("t5_flush_rd", 32'(RdW), 32'd0);
    step(1, 0, 0, 1, F3_W, 32'h44, 32'h55, 5'd0, 0, 1);
    load(F3_W, 32'h44, 5'd10);
    chk("t5_flush_store", ReadDataW, 32'h55);

    step(0, 0, 0, 1, F3_W, 32'h48, 32'hAAAAAAAA, 5'd0, 0, 0);
    chk("t6_rst_rd", 32'(RdW), 32'd0);
    chk("t6_rst_data", ReadDataW, 32'h0);
    chk("t6_rst_err", 32'(MisalignErr), 32'h0);
    load(F3_W, 32'h48, 5'd11);
    chk("t6_mem_kept", ReadDataW, 32'h0);

    step(1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_memory_stage_cc
